// File: rtl/jk_bank_seq.sv
// jk_bank_seq: command sequencer for an external bank of WIDTH JK flip-flops.
// It accepts one command at a time over valid/ready. It then drives registered
// J/K excitation for one or more steps, reading the bank's Q back between steps.
// Optional build macro: JK_BANK_CHECK_EN. When it is defined, the final bank value
// is compared with the value the command should produce, and a mismatch sets the
// sticky err flag. Without it, err is tied low.
module jk_bank_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_SET    = 3'd1;
    localparam logic [2:0] OP_RESET  = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_LOAD   = 3'd4;
    localparam logic [2:0] OP_CNT_UP = 3'd5;
    localparam logic [2:0] OP_CNT_DN = 3'd6;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             accept_s;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] remaining_r;
    logic [CNT_W-1:0] steps_s;
    logic [2:0]       exc_op_s;
    logic [WIDTH-1:0] exc_data_s;
    logic [2*WIDTH-1:0] exc_s;
    logic [WIDTH-1:0] j_r;
    logic [WIDTH-1:0] k_r;
    logic             cmd_ready_r;
    logic             busy_r;
    logic             done_r;

    // True for the multi-step counting opcodes.
    function automatic logic is_count(input logic [2:0] op);
        return (op == OP_CNT_UP) || (op == OP_CNT_DN);
    endfunction

    // Per-bit J/K excitation for one step of op, given the bank's present value.
    // The count terms are ripple-carry/borrow enables, so a bit toggles only when
    // every lower bit is 1 (up) or 0 (down). Wrap falls out of plain toggling.
    function automatic logic [2*WIDTH-1:0] excite(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] data,
                                                  input logic [WIDTH-1:0] qv);
        logic [WIDTH-1:0] up_v;
        logic [WIDTH-1:0] dn_v;
        logic [WIDTH-1:0] jv;
        logic [WIDTH-1:0] kv;
        up_v[0] = 1'b1;
        dn_v[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_v[i] = up_v[i-1] & qv[i-1];
            dn_v[i] = dn_v[i-1] & ~qv[i-1];
        end
        case (op)
            OP_SET: begin
                jv = data;
                kv = {WIDTH{1'b0}};
            end
            OP_RESET: begin
                jv = {WIDTH{1'b0}};
                kv = data;
            end
            OP_TOGGLE: begin
                jv = data;
                kv = data;
            end
            OP_LOAD: begin
                jv = data;
                kv = ~data;
            end
            OP_CNT_UP: begin
                jv = up_v;
                kv = up_v;
            end
            OP_CNT_DN: begin
                jv = dn_v;
                kv = dn_v;
            end
            default: begin
                jv = {WIDTH{1'b0}};
                kv = {WIDTH{1'b0}};
            end
        endcase
        return {jv, kv};
    endfunction

    // Next-state decode: accept only in IDLE, alternate STEP/SETTLE until no steps remain.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = STEP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STEP: begin
                state_nxt_s = SETTLE;
            end
            SETTLE: begin
                if (remaining_r != {CNT_W{1'b0}}) begin
                    state_nxt_s = STEP;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Excitation source: the live command at accept, the latched command on later steps.
    always_comb begin
        exc_op_s   = op_r;
        exc_data_s = data_r;
        if (state_r == IDLE) begin
            exc_op_s   = cmd_op;
            exc_data_s = cmd_data;
        end else begin
            exc_op_s   = op_r;
            exc_data_s = data_r;
        end
        exc_s = excite(exc_op_s, exc_data_s, q);
        if (is_count(cmd_op) && (cmd_count != {CNT_W{1'b0}})) begin
            steps_s = cmd_count;
        end else begin
            steps_s = CNT_W'(1);
        end
    end

    // State and output registers; j/k are non-zero only while the next state is STEP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            j_r         <= {WIDTH{1'b0}};
            k_r         <= {WIDTH{1'b0}};
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cmd_ready_r <= (state_nxt_s == IDLE);
            busy_r      <= (state_nxt_s != IDLE);
            done_r      <= (state_nxt_s == DONE);
            if (state_nxt_s == STEP) begin
                j_r <= exc_s[2*WIDTH-1:WIDTH];
                k_r <= exc_s[WIDTH-1:0];
            end else begin
                j_r <= {WIDTH{1'b0}};
                k_r <= {WIDTH{1'b0}};
            end
        end
    end

    // Command latch and step counter (decremented as each STEP is sampled by the bank).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r        <= OP_HOLD;
            data_r      <= {WIDTH{1'b0}};
            remaining_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            op_r        <= cmd_op;
            data_r      <= cmd_data;
            remaining_r <= steps_s;
        end else if (state_r == STEP) begin
            remaining_r <= remaining_r - CNT_W'(1);
        end else begin
            remaining_r <= remaining_r;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign j         = j_r;
    assign k         = k_r;

`ifdef JK_BANK_CHECK_EN
    logic [WIDTH-1:0] q_start_r;
    logic [CNT_W-1:0] steps_r;
    logic [WIDTH-1:0] expect_s;
    logic             err_r;

    // Snapshot of the bank and step count at accept, the reference for the final check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_start_r <= {WIDTH{1'b0}};
            steps_r   <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            q_start_r <= q;
            steps_r   <= steps_s;
        end else begin
            q_start_r <= q_start_r;
            steps_r   <= steps_r;
        end
    end

    // Value the bank should hold once the whole command has been applied (mod 2^WIDTH).
    always_comb begin
        expect_s = q_start_r;
        case (op_r)
            OP_SET:    expect_s = q_start_r | data_r;
            OP_RESET:  expect_s = q_start_r & ~data_r;
            OP_TOGGLE: expect_s = q_start_r ^ data_r;
            OP_LOAD:   expect_s = data_r;
            OP_CNT_UP: expect_s = q_start_r + WIDTH'(steps_r);
            OP_CNT_DN: expect_s = q_start_r - WIDTH'(steps_r);
            default:   expect_s = q_start_r;
        endcase
    end

    // Sticky mismatch flag, evaluated on the final SETTLE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if ((state_r == SETTLE) && (state_nxt_s == DONE) && (q != expect_s)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jk_bank_seq.sv
// Testbench for jk_bank_seq: a behavioural JK bank closes the loop on j/k/q.
// The stimulus pushes the expected final q and latency per command into a
// scoreboard, and a monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_jk_bank_seq;
    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
`ifdef JK_BANK_CHECK_EN
    localparam logic CHECK_ON = 1'b1;
`else
    localparam logic CHECK_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'd0;
    logic [WIDTH-1:0] cmd_data = 4'd0;
    logic [CNT_W-1:0] cmd_count = 8'd0;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             err;

    logic [WIDTH-1:0] bank_q = 4'b0000;
    logic             preset_en = 1'b0;
    logic [WIDTH-1:0] preset_val = 4'b0000;
    logic             force_zero = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_done_cyc = -1;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] q;
        int               lat;
        int               acc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [WIDTH-1:0] up_seq [5] = '{4'b1111, 4'b0000, 4'b0001, 4'b0010, 4'b0011};

    jk_bank_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .j         (j),
        .k         (k),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    assign q = bank_q;

    always #5 clk = ~clk;

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural JK flip-flop bank, not affected by rst; preset/force for setup
    always @(posedge clk) begin
        if (preset_en) begin
            bank_q <= preset_val;
        end else if (force_zero) begin
            bank_q <= 4'b0000;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({j[i], k[i]})
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: bank_q[i] <= bank_q[i];
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // monitor: idle j/k must be zero; on done pop scoreboard and compare q + latency
    always @(negedge clk) begin
        if (!rst) begin
            if (!busy) check("idle_jk_zero", {24'd0, j, k}, 32'd0);
            if (done) begin
                last_done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check({mon_e.name, "_q"}, {28'd0, q}, {28'd0, mon_e.q});
                    check({mon_e.name, "_lat"}, cyc - mon_e.acc, mon_e.lat);
                end
            end
        end
    end

    task automatic preset(input logic [WIDTH-1:0] v);
        @(negedge clk);
        cmd_valid  = 1'b0;
        preset_val = v;
        preset_en  = 1'b1;
        @(posedge clk);
        #1 preset_en = 1'b0;
    endtask

    task automatic send(input string name, input logic [2:0] op, input logic [WIDTH-1:0] data,
                        input logic [CNT_W-1:0] count, input logic [WIDTH-1:0] q_exp,
                        input int lat, input bit chk_b2b);
        int   waitc;
        exp_t e;
        waitc = 0;
        @(negedge clk);
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = count;
        cmd_valid = 1'b1;
        while (!cmd_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_accept_timeout: got cmd_ready=0 for 100 cycles, expected 1", name);
            cmd_valid = 1'b0;
        end else begin
            if (chk_b2b) check({name, "_accept_after_done"}, cyc, last_done_cyc + 1);
            e.name = name;
            e.q    = q_exp;
            e.lat  = lat;
            e.acc  = cyc;
            exp_q.push_back(e);
            @(posedge clk);
        end
    endtask

    task automatic finish_cmd();
        int waitc;
        waitc = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (busy && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: got busy=1 for 100 cycles, expected 0");
        end
    endtask

    initial begin
        // reset state with bank preset to 1010
        rst = 1'b1;
        preset_val = 4'b1010;
        preset_en  = 1'b1;
        repeat (2) @(posedge clk);
        #1 preset_en = 1'b0;
        @(negedge clk);
        check("reset_j", {28'd0, j}, 32'd0);
        check("reset_k", {28'd0, k}, 32'd0);
        check("reset_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_q", {28'd0, q}, 32'hA);
        rst = 1'b0;

        // TOGGLE 1111 accepted, then reset asserted mid-STEP: abandoned, bank holds
        cmd_op = 3'd3;
        cmd_data = 4'b1111;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 check("abort_step_j", {28'd0, j}, 32'hF);
        cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("abort_rst_j", {28'd0, j}, 32'd0);
        check("abort_rst_k", {28'd0, k}, 32'd0);
        check("abort_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_rst_busy", {31'd0, busy}, 32'd0);
        check("abort_rst_err", {31'd0, err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_bank_held", {28'd0, q}, 32'hA);
        rst = 1'b0;

        // LOAD 0110 from 1001
        preset(4'b1001);
        send("load", 3'd4, 4'b0110, 8'd0, 4'b0110, 3, 1'b0);
        @(negedge clk);
        check("load_step_j", {28'd0, j}, 32'h6);
        check("load_step_k", {28'd0, k}, 32'h9);
        @(negedge clk);
        check("load_settle_q", {28'd0, q}, 32'h6);
        finish_cmd();

        // TOGGLE/SET/RESET chained with cmd_valid held
        preset(4'b0101);
        send("toggle", 3'd3, 4'b0011, 8'd0, 4'b0110, 3, 1'b0);
        send("set", 3'd1, 4'b1000, 8'd0, 4'b1110, 3, 1'b1);
        send("reset", 3'd2, 4'b0100, 8'd0, 4'b1010, 3, 1'b1);
        finish_cmd();

        // CNT_UP 5 from 1110 with wrap, then chained down counts and hold ops
        preset(4'b1110);
        send("cnt_up5", 3'd5, 4'b0000, 8'd5, 4'b0011, 11, 1'b0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            @(negedge clk);
            check($sformatf("cnt_up_step%0d_q", s), {28'd0, q}, {28'd0, up_seq[s]});
        end
        send("cnt_dn3", 3'd6, 4'b0000, 8'd3, 4'b0000, 7, 1'b1);
        send("cnt_dn0", 3'd6, 4'b0000, 8'd0, 4'b1111, 3, 1'b1);
        send("hold", 3'd0, 4'b1010, 8'd0, 4'b1111, 3, 1'b1);
        send("reserved", 3'd7, 4'b0101, 8'd9, 4'b1111, 3, 1'b1);
        finish_cmd();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("err_clean", {31'd0, err}, 32'd0);

        // bank forced to 0000 during LOAD 1111: err only when the check is built
        preset(4'b0000);
        force_zero = 1'b1;
        send("load_forced", 3'd4, 4'b1111, 8'd0, 4'b0000, 3, 1'b0);
        finish_cmd();
        check("err_after_mismatch", {31'd0, err}, {31'd0, CHECK_ON});
        repeat (3) @(negedge clk);
        check("err_sticky", {31'd0, err}, {31'd0, CHECK_ON});
        force_zero = 1'b0;
        rst = 1'b1;
        #1 check("err_cleared_by_rst", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("final_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000ns, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
